// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the single-port memory controller.
// Imported by the arbiter and the controller top.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_ACCESS = 2'd1,
    MC_DONE   = 2'd2
  } mc_state_t;

  localparam logic MC_REQ_IF  = 1'b0;
  localparam logic MC_REQ_MEM = 1'b1;

  localparam logic MC_OP_RD = 1'b0;
  localparam logic MC_OP_WR = 1'b1;

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Fixed-priority pick between fetch and data requests (store > load > fetch)
// plus the registers holding the accepted request for the whole access.
module mc_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int AW     = 30,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              accept,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              any_req,
  output logic [AW-1:0]     lat_addr,
  output logic [DATA_W-1:0] lat_wdata,
  output logic              lat_op,
  output logic              lat_id
);

  logic              g_wr;
  logic              g_rd;
  logic              g_if;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_op;
  logic              sel_id;

  // A load colliding with a store is dropped in favour of the store.
  assign g_wr    = wr;
  assign g_rd    = rd & ~wr;
  assign g_if    = if_req & ~rd & ~wr;
  assign any_req = if_req | rd | wr;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_op    = MC_OP_RD;
    sel_id    = MC_REQ_IF;
    unique case (1'b1)
      g_wr: begin
        sel_addr  = mem_addr;
        sel_wdata = wdata;
        sel_op    = MC_OP_WR;
        sel_id    = MC_REQ_MEM;
      end
      g_rd: begin
        sel_addr = mem_addr;
        sel_id   = MC_REQ_MEM;
      end
      g_if: begin
        sel_addr = if_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_op    <= MC_OP_RD;
      lat_id    <= MC_REQ_IF;
    end else if (accept) begin
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_op    <= sel_op;
      lat_id    <= sel_id;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port SRAM controller shared by Fetch and Memory stages.
// Fixed-latency accesses; stalls the pipeline while an access is pending.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_mc_req,
  input  logic [ADDR_W-1:0] if_mc_addr,
  output logic [DATA_W-1:0] mc_if_data,
  output logic              mc_if_ready,
  input  logic              mem_mc_readmem,
  input  logic              mem_mc_writemem,
  input  logic [ADDR_W-1:0] mem_mc_addr,
  input  logic [DATA_W-1:0] mem_mc_wdata,
  output logic [DATA_W-1:0] mc_mem_data,
  output logic              mc_mem_ready,
  output logic              mc_stall,
  output logic              mc_ram_en,
  output logic              mc_ram_we,
  output logic [ADDR_W-3:0] mc_ram_addr,
  output logic [DATA_W-1:0] mc_ram_wdata,
  input  logic [DATA_W-1:0] ram_mc_rdata
);

  localparam int AW = ADDR_W - 2;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  mc_state_t         state;
  mc_state_t         nxt;
  logic [3:0]        cnt;
  logic              any_req;
  logic              data_req;
  logic              accept;
  logic              last;
  logic [AW-1:0]     lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_op;
  logic              lat_id;
  logic              unused_lo;

  // Byte offset bits are irrelevant: word accesses only.
  assign unused_lo = ^{if_mc_addr[1:0], mem_mc_addr[1:0]};

  assign data_req = mem_mc_readmem | mem_mc_writemem;
  assign accept   = (state == MC_IDLE) && any_req;
  assign last     = (state == MC_ACCESS) && (cnt == 4'd0);

  mc_arbiter #(
    .AW     (AW),
    .DATA_W (DATA_W)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .accept    (accept),
    .if_req    (if_mc_req),
    .if_addr   (if_mc_addr[ADDR_W-1:2]),
    .rd        (mem_mc_readmem),
    .wr        (mem_mc_writemem),
    .mem_addr  (mem_mc_addr[ADDR_W-1:2]),
    .wdata     (mem_mc_wdata),
    .any_req   (any_req),
    .lat_addr  (lat_addr),
    .lat_wdata (lat_wdata),
    .lat_op    (lat_op),
    .lat_id    (lat_id)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= MC_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      MC_IDLE:   if (any_req) nxt = MC_ACCESS;
      MC_ACCESS: if (cnt == 4'd0) nxt = MC_DONE;
      MC_DONE:   nxt = MC_IDLE;
      default:   nxt = MC_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == MC_ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mc_if_data  <= '0;
      mc_mem_data <= '0;
    end else if (last && lat_op == MC_OP_RD) begin
      if (lat_id == MC_REQ_IF) mc_if_data  <= ram_mc_rdata;
      else                     mc_mem_data <= ram_mc_rdata;
    end
  end

  always_comb begin
    mc_ram_en    = 1'b0;
    mc_ram_we    = 1'b0;
    mc_ram_addr  = '0;
    mc_ram_wdata = '0;
    mc_if_ready  = 1'b0;
    mc_mem_ready = 1'b0;
    mc_stall     = 1'b0;
    unique case (state)
      MC_IDLE: mc_stall = any_req;
      MC_ACCESS: begin
        mc_ram_en    = 1'b1;
        mc_ram_we    = (lat_op == MC_OP_WR);
        mc_ram_addr  = lat_addr;
        mc_ram_wdata = lat_wdata;
        mc_stall     = 1'b1;
      end
      // Release the pipeline only if the other requester is not waiting.
      MC_DONE: begin
        if (lat_id == MC_REQ_MEM) begin
          mc_mem_ready = 1'b1;
          mc_stall     = if_mc_req;
        end else begin
          mc_if_ready = 1'b1;
          mc_stall    = data_req;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl (MEM_LAT=2 and MEM_LAT=1 builds).
module tb_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_ready;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] m_data;
  logic        m_ready;
  logic        stall;
  logic        ram_en;
  logic        ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic        b_if_req = 1'b0;
  logic [31:0] b_if_addr = '0;
  logic [31:0] b_if_data;
  logic        b_if_ready;
  logic [31:0] b_m_data;
  logic        b_m_ready;
  logic        b_stall;
  logic        b_ram_en;
  logic        b_ram_we;
  logic [29:0] b_ram_addr;
  logic [31:0] b_ram_wdata;
  logic [31:0] b_ram_rdata;

  int checks   = 0;
  int failures = 0;

  logic [4:0] ctl;
  logic [4:0] b_ctl;
  assign ctl   = {stall, ram_en, ram_we, if_ready, m_ready};
  assign b_ctl = {b_stall, b_ram_en, b_ram_we, b_if_ready, b_m_ready};

  always #5 clock = ~clock;

  // SRAM models: data only valid on the last cycle of a held enable.
  logic [31:0] mem_a [256] = '{
    0: 32'h0000_0013,
    4: 32'h2008_000A,
    default: 32'h0
  };
  int ecnt_a = 0;
  int ecnt_b = 0;

  always @(posedge clock) begin
    if (ram_en) begin
      ecnt_a <= ecnt_a + 1;
      if (ram_we) mem_a[ram_addr[7:0]] <= ram_wdata;
    end else begin
      ecnt_a <= 0;
    end
    if (b_ram_en) ecnt_b <= ecnt_b + 1;
    else          ecnt_b <= 0;
  end

  assign ram_rdata = (ram_en && ecnt_a == 1) ?
    mem_a[ram_addr[7:0]] : 32'hBAD0_BAD0;
  assign b_ram_rdata = (b_ram_en && ecnt_b == 0) ?
    mem_a[b_ram_addr[7:0]] : 32'hBAD0_BAD0;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .if_mc_req       (if_req),
    .if_mc_addr      (if_addr),
    .mc_if_data      (if_data),
    .mc_if_ready     (if_ready),
    .mem_mc_readmem  (rd),
    .mem_mc_writemem (wr),
    .mem_mc_addr     (m_addr),
    .mem_mc_wdata    (wdata),
    .mc_mem_data     (m_data),
    .mc_mem_ready    (m_ready),
    .mc_stall        (stall),
    .mc_ram_en       (ram_en),
    .mc_ram_we       (ram_we),
    .mc_ram_addr     (ram_addr),
    .mc_ram_wdata    (ram_wdata),
    .ram_mc_rdata    (ram_rdata)
  );

  mem_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clock           (clock),
    .reset           (reset),
    .if_mc_req       (b_if_req),
    .if_mc_addr      (b_if_addr),
    .mc_if_data      (b_if_data),
    .mc_if_ready     (b_if_ready),
    .mem_mc_readmem  (1'b0),
    .mem_mc_writemem (1'b0),
    .mem_mc_addr     (32'h0),
    .mem_mc_wdata    (32'h0),
    .mc_mem_data     (b_m_data),
    .mc_mem_ready    (b_m_ready),
    .mc_stall        (b_stall),
    .mc_ram_en       (b_ram_en),
    .mc_ram_we       (b_ram_we),
    .mc_ram_addr     (b_ram_addr),
    .mc_ram_wdata    (b_ram_wdata),
    .ram_mc_rdata    (b_ram_rdata)
  );

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    checks++;
    if ({ctl, ram_addr, ram_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_ctl got=%b/%h/%h want=0/0/0",
               ctl, ram_addr, ram_wdata);
    end
    checks++;
    if ({if_data, m_data} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h want=0/0", if_data, m_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_fetch();
    logic [4:0] e [5];
    e = '{5'b10000, 5'b11000, 5'b11000, 5'b00010, 5'b00000};
    cyc();
    if_req  = 1'b1;
    if_addr = 32'h10;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL fetch_ctl c%0d got=%b want=%b", i, ctl, e[i]);
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (ram_addr !== 30'd4) begin
          failures++;
          $display("FAIL fetch_addr c%0d got=%0d want=4", i, ram_addr);
        end
      end
      if (i == 3) begin
        checks++;
        if (if_data !== 32'h2008_000A) begin
          failures++;
          $display("FAIL fetch_data got=%h want=2008000a", if_data);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_load();
    logic [4:0] e [5];
    logic [4:0] l [4];
    e = '{5'b10000, 5'b11100, 5'b11100, 5'b00001, 5'b00000};
    l = '{5'b10000, 5'b11000, 5'b11000, 5'b00001};
    wr     = 1'b1;
    m_addr = 32'h40;
    wdata  = 32'hDEAD_BEEF;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL store_ctl c%0d got=%b want=%b", i, ctl, e[i]);
      end
      if (i == 1) begin
        checks++;
        if ({ram_addr, ram_wdata} !== {30'd16, 32'hDEAD_BEEF}) begin
          failures++;
          $display("FAIL store_bus got=%0d/%h want=16/deadbeef",
                   ram_addr, ram_wdata);
        end
      end
      if (i == 3) wr = 1'b0;
    end
    rd = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      checks++;
      if (ctl !== l[i]) begin
        failures++;
        $display("FAIL load_ctl c%0d got=%b want=%b", i, ctl, l[i]);
      end
    end
    checks++;
    if (m_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_data got=%h want=deadbeef", m_data);
    end
    rd = 1'b0;
    cyc();
  endtask

  task automatic test_coincide();
    logic [4:0] e [9];
    e = '{5'b10000, 5'b11000, 5'b11000, 5'b10001, 5'b10000,
          5'b11000, 5'b11000, 5'b00010, 5'b00000};
    if_req  = 1'b1;
    if_addr = 32'h0;
    rd      = 1'b1;
    m_addr  = 32'h40;
    #1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cyc();
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL both_ctl c%0d got=%b want=%b", i, ctl, e[i]);
      end
      if (i == 1 || i == 5) begin
        checks++;
        if (ram_addr !== (i == 1 ? 30'd16 : 30'd0)) begin
          failures++;
          $display("FAIL both_addr c%0d got=%0d want=%0d",
                   i, ram_addr, (i == 1 ? 16 : 0));
        end
      end
      if (i == 3) begin
        checks++;
        if (m_data !== 32'hDEAD_BEEF) begin
          failures++;
          $display("FAIL both_mdata got=%h want=deadbeef", m_data);
        end
        rd = 1'b0;
      end
      if (i == 7) begin
        checks++;
        if (if_data !== 32'h0000_0013) begin
          failures++;
          $display("FAIL both_idata got=%h want=00000013", if_data);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_rd_wr();
    logic [4:0] e [5];
    e = '{5'b10000, 5'b11100, 5'b11100, 5'b00001, 5'b00000};
    rd     = 1'b1;
    wr     = 1'b1;
    m_addr = 32'h80;
    wdata  = 32'h1234_5678;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL rdwr_ctl c%0d got=%b want=%b", i, ctl, e[i]);
      end
      if (i == 3) begin
        checks++;
        if (m_data !== 32'hDEAD_BEEF) begin
          failures++;
          $display("FAIL rdwr_mdata got=%h want=deadbeef", m_data);
        end
        checks++;
        if (mem_a[32] !== 32'h1234_5678) begin
          failures++;
          $display("FAIL rdwr_mem got=%h want=12345678", mem_a[32]);
        end
        rd = 1'b0;
        wr = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] e [4];
    e = '{5'b10000, 5'b11000, 5'b11000, 5'b00010};
    if_req  = 1'b1;
    if_addr = 32'h10;
    cyc();
    checks++;
    if (ctl !== 5'b11000) begin
      failures++;
      $display("FAIL rmid_pre got=%b want=11000", ctl);
    end
    reset  = 1'b0;
    if_req = 1'b0;
    #1;
    checks++;
    if ({ctl, ram_addr, if_data, m_data} !== '0) begin
      failures++;
      $display("FAIL rmid_async got=%b/%0d/%h/%h want=0",
               ctl, ram_addr, if_data, m_data);
    end
    cyc();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (ctl !== 5'b00000) begin
        failures++;
        $display("FAIL rmid_idle c%0d got=%b want=00000", i, ctl);
      end
    end
    if_req = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL rmid_fetch c%0d got=%b want=%b", i, ctl, e[i]);
      end
    end
    checks++;
    if (if_data !== 32'h2008_000A) begin
      failures++;
      $display("FAIL rmid_data got=%h want=2008000a", if_data);
    end
    if_req = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] d [3];
    logic [4:0]  e [3];
    int k;
    a = '{32'h13, 32'h10, 32'h00};
    d = '{32'h2008_000A, 32'h2008_000A, 32'h0000_0013};
    e = '{5'b10000, 5'b11000, 5'b00010};
    k = 0;
    b_if_req  = 1'b1;
    b_if_addr = a[0];
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      checks++;
      if (b_ctl !== (i == 9 ? 5'b00000 : e[i % 3])) begin
        failures++;
        $display("FAIL b2b_ctl c%0d got=%b want=%b",
                 i, b_ctl, (i == 9 ? 5'b00000 : e[i % 3]));
      end
      if (i % 3 == 2) begin
        checks++;
        if (b_if_data !== d[k]) begin
          failures++;
          $display("FAIL b2b_data n%0d got=%h want=%h",
                   k, b_if_data, d[k]);
        end
        k++;
        if (k < 3) b_if_addr = a[k];
        else       b_if_req  = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_coincide();
    test_rd_wr();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
